prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter: DEPTH, 4, instruction buffer entries and maximum fetch credits; power of two, 2..16.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: redirect_valid  in  1  flush and restart fetch; a one-cycle pulse.
REQ-007 Port: redirect_pc  in  32  restart address; bits [1:0] ignored and forced to 0.
REQ-008 Port: imem_req  out  1  request valid to instruction memory.
REQ-009 Port: imem_addr  out  32  word-aligned fetch address.
REQ-010 Port: imem_gnt  in  1  request accepted this cycle; ignored when imem_req=0.
REQ-011 Port: imem_rvalid  in  1  in-order read response valid, at least 1 cycle after its grant.
REQ-012 Port: imem_rdata  in  32  response instruction word.
REQ-013 Port: instr_valid  out  1  buffered instruction available.
REQ-014 Port: instr_ready  in  1  consumer accepts instruction.
REQ-015 Port: instruction  out  32  head instruction word.
REQ-016 Port: instr_pc  out  32  address of the head instruction.

Function
REQ-017 Fetch PC register: reset to RESET_PC; +4 on each grant (imem_req & imem_gnt); wraps modulo 2^32; loaded with {redirect_pc[31:2],2'b00} on redirect.
REQ-018 imem_addr SHALL equal the fetch PC; it SHALL stay stable while imem_req=1 and no grant has occurred, except when a redirect withdraws the request.
REQ-019 imem_req SHALL be 1 iff reset=0, redirect_valid=0 and (buffer count + outstanding count) < DEPTH.
REQ-020 Outstanding counter (0..DEPTH): +1 on grant, -1 on response, unchanged when both occur in the same cycle.
REQ-021 Accepted responses SHALL be written into the FIFO with instr_pc taken from a response-PC register; that register resets to RESET_PC, increments by 4 per accepted response and loads the aligned redirect_pc on redirect.
REQ-022 Response-to-instr_valid latency SHALL be exactly 1 cycle when the buffer is empty; no combinational path from imem_rdata to instruction.
REQ-023 Pop on instr_valid & instr_ready; simultaneous push and pop leaves the count unchanged, including when count=DEPTH.
REQ-024 The buffer SHALL never overflow; a response with outstanding=0 is a protocol error and SHALL be ignored.
REQ-025 instr_valid SHALL be 0 whenever the count=0 or redirect_valid=1; instruction and instr_pc SHALL be 0 whenever instr_valid=0.
REQ-026 Redirect: empty the buffer, set the discard counter to outstanding minus imem_rvalid, and drop any response arriving in the redirect cycle.
REQ-027 While the discard counter > 0, each response SHALL be dropped and decrement the counter; new requests may issue, within credit, during this draining.
REQ-028 A redirect that arrives while the discard counter > 0 SHALL apply REQ-026 again, so all outstanding responses from the old stream are dropped.

Reset
REQ-029 When reset=1: fetch PC and response PC = RESET_PC; buffer, outstanding and discard counters = 0; imem_req=0; instr_valid=0; instruction=0; instr_pc=0.
REQ-030 Reset SHALL take priority over redirect and all handshakes; responses to pre-reset requests are the memory's responsibility and are not tracked.

Verification
REQ-031 Streaming (imem_gnt=1, rvalid 1 cycle after grant, instr_ready=1): imem_addr 0,4,8,...; instr_pc 0,4,8,... in order; first instr_valid 2 cycles after the first grant.
REQ-032 Backpressure (DEPTH=4, instr_ready=0): exactly 4 grants, then imem_req=0; each later pop re-enables exactly one request.
REQ-033 Redirect to 0x100 with 2 requests outstanding: both responses dropped; the next instr_valid has instr_pc=0x100 and the word fetched from 0x100.
REQ-034 Redirect with redirect_pc=0x203 in the same cycle as imem_rvalid: that response is dropped; the next imem_addr=0x200.
REQ-035 Wrap-around: redirect to 0xFFFF_FFFC -> imem_addr 0xFFFF_FFFC then 0x0000_0000; instr_pc follows.
REQ-036 Reset asserted with 3 buffered entries: the next cycle has instr_valid=0 and imem_req=0; the first address after reset is RESET_PC.

Source files
------------

// File: rtl/prefetch_if.sv
// Bundles the prefetch unit's redirect, instruction-memory and consumer signals.
// The master modport is the prefetch unit; the slave modport is its environment
// (core front end plus instruction memory).
interface prefetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  instr_ready,
        output imem_req, imem_addr,
        output instr_valid, instruction, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        output instr_ready,
        input  imem_req, imem_addr,
        input  instr_valid, instruction, instr_pc
    );
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues word-aligned fetches against a credit limit
// of DEPTH (buffered + outstanding), buffers in-order responses in a small FIFO
// and drops responses belonging to a stream that was abandoned by a redirect.
module prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic        clk,
    input logic        reset,
    prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   word_d [DEPTH];
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   pc_d [DEPTH];

    logic [CW:0]   used;
    logic [31:0]   redirect_aligned;
    logic          req;
    logic          grant;
    logic          rsp_ok;
    logic          push;
    logic          valid;
    logic          pop;

    // Handshake decode and next-state computation for every register.
    always_comb begin
        used             = {1'b0, count_q} + {1'b0, outst_q};
        redirect_aligned = {bus.redirect_pc[31:2], 2'b00};
        req    = !reset && !bus.redirect_valid && (used < (CW+1)'(DEPTH));
        grant  = req && bus.imem_gnt;
        rsp_ok = bus.imem_rvalid && (outst_q != '0);
        push   = rsp_ok && !bus.redirect_valid && (discard_q == '0);
        valid  = !reset && !bus.redirect_valid && (count_q != '0);
        pop    = valid && bus.instr_ready;

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        word_d     = word_q;
        pc_d       = pc_q;

        if (grant && !rsp_ok) begin
            outst_d = outst_q + CW'(1);
        end else if (!grant && rsp_ok) begin
            outst_d = outst_q - CW'(1);
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = outst_q - CW'(rsp_ok);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_ok && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                word_d[wr_ptr_q] = bus.imem_rdata;
                pc_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                rsp_pc_d         = rsp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!push && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset clears control state, buffer storage just holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            word_q     <= word_d;
            pc_q       <= pc_d;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = valid;
    assign bus.instruction = valid ? word_q[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = valid ? pc_q[rd_ptr_q] : 32'h0;
endmodule
